// File: rtl/bsg_chip_mem_link_if.sv
// Core-side command/response and link flit bundle for bsg_chip_mem_link.
// The slave modport is the link block; master is the core/link side that drives it.
interface bsg_chip_mem_link_if #(
    parameter int msg_width_p  = 136,
    parameter int flit_width_p = 32
);
    logic [msg_width_p-1:0]  mem_cmd_i;
    logic                    mem_cmd_v_i;
    logic                    mem_cmd_ready_o;
    logic [flit_width_p-1:0] link_data_o;
    logic                    link_v_o;
    logic                    link_ready_i;
    logic [flit_width_p-1:0] link_data_i;
    logic                    link_v_i;
    logic                    link_ready_o;
    logic [msg_width_p-1:0]  mem_resp_o;
    logic                    mem_resp_v_o;
    logic                    mem_resp_yumi_i;

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, link_ready_i, link_data_i, link_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, link_data_o, link_v_o, link_ready_o, mem_resp_o, mem_resp_v_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, link_ready_i, link_data_i, link_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, link_data_o, link_v_o, link_ready_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bsg_chip_mem_link.sv
// Serializes memory commands into link flits and reassembles inbound flits into responses.
// The two directions share only clock and reset.

module bsg_chip_mem_link_chk (
    input logic clk_i,
    input logic reset_i,
    input logic resp_v_i,
    input logic resp_yumi_i
);
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(resp_yumi_i && !resp_v_i))
        else $error("bsg_chip_mem_link: mem_resp_yumi_i asserted with no response pending");
endmodule

module bsg_chip_mem_link #(
    parameter int msg_width_p  = 136,
    parameter int flit_width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bsg_chip_mem_link_if.slave link_if
);
    localparam int n_flits_lp   = (msg_width_p + flit_width_p - 1) / flit_width_p;
    localparam int pad_width_lp = n_flits_lp * flit_width_p;
    localparam int cnt_width_lp = (n_flits_lp > 1) ? $clog2(n_flits_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(n_flits_lp - 1);

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;
    localparam logic [0:0] RX_RECV = 1'b0;
    localparam logic [0:0] RX_FULL = 1'b1;

    logic [0:0]              tx_state_q, tx_state_d;
    logic [cnt_width_lp-1:0] tx_cnt_q, tx_cnt_d;
    logic [pad_width_lp-1:0] tx_data_q, tx_data_d;
    logic [0:0]              rx_state_q, rx_state_d;
    logic [cnt_width_lp-1:0] rx_cnt_q, rx_cnt_d;
    logic [pad_width_lp-1:0] rx_data_q, rx_data_d;

    logic tx_hs_s;
    logic tx_last_s;
    logic cmd_ready_s;
    logic cmd_acc_s;
    logic rx_hs_s;

    // Transmit path: the current flit always sits in the low bits of tx_data_q.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_hs_s    = (tx_state_q == TX_SEND) && link_if.link_ready_i;
        tx_last_s  = (tx_cnt_q == last_cnt_lp);
        case (tx_state_q)
            TX_IDLE: cmd_ready_s = 1'b1;
            TX_SEND: cmd_ready_s = tx_hs_s && tx_last_s;
            default: cmd_ready_s = 1'b0;
        endcase
        cmd_acc_s = cmd_ready_s && link_if.mem_cmd_v_i;
        if (cmd_acc_s) begin
            tx_state_d = TX_SEND;
            tx_cnt_d   = {cnt_width_lp{1'b0}};
            tx_data_d  = pad_width_lp'(link_if.mem_cmd_i);
        end else if (tx_hs_s) begin
            if (tx_last_s) begin
                tx_state_d = TX_IDLE;
            end else begin
                tx_cnt_d  = tx_cnt_q + cnt_width_lp'(1);
                tx_data_d = tx_data_q >> flit_width_p;
            end
        end else begin
            tx_state_d = tx_state_q;
        end
    end

    // Receive path: flits enter at the top and shift down, so flit 0 ends in the LSBs.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_hs_s    = (rx_state_q == RX_RECV) && link_if.link_v_i;
        case (rx_state_q)
            RX_RECV: begin
                if (rx_hs_s) begin
                    rx_data_d = (rx_data_q >> flit_width_p)
                              | (pad_width_lp'(link_if.link_data_i) << (pad_width_lp - flit_width_p));
                    if (rx_cnt_q == last_cnt_lp) begin
                        rx_cnt_d   = {cnt_width_lp{1'b0}};
                        rx_state_d = RX_FULL;
                    end else begin
                        rx_cnt_d = rx_cnt_q + cnt_width_lp'(1);
                    end
                end else begin
                    rx_state_d = RX_RECV;
                end
            end
            RX_FULL: begin
                if (link_if.mem_resp_yumi_i) begin
                    rx_state_d = RX_RECV;
                end else begin
                    rx_state_d = RX_FULL;
                end
            end
            default: rx_state_d = RX_RECV;
        endcase
    end

    // State and data registers for both paths.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= {cnt_width_lp{1'b0}};
            tx_data_q  <= {pad_width_lp{1'b0}};
            rx_state_q <= RX_RECV;
            rx_cnt_q   <= {cnt_width_lp{1'b0}};
            rx_data_q  <= {pad_width_lp{1'b0}};
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign link_if.mem_cmd_ready_o = cmd_ready_s;
    assign link_if.link_v_o        = (tx_state_q == TX_SEND);
    assign link_if.link_data_o     = tx_data_q[flit_width_p-1:0];
    assign link_if.link_ready_o    = (rx_state_q == RX_RECV);
    assign link_if.mem_resp_v_o    = (rx_state_q == RX_FULL);
    assign link_if.mem_resp_o      = rx_data_q[msg_width_p-1:0];

    bsg_chip_mem_link_chk chk (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .resp_v_i    (link_if.mem_resp_v_o),
        .resp_yumi_i (link_if.mem_resp_yumi_i)
    );
endmodule

// File: tb/tb_bsg_chip_mem_link.sv
// Bench for bsg_chip_mem_link: default (5-flit) and single-flit instances against a queue model.
module tb_bsg_chip_mem_link;
    localparam int MW = 136;
    localparam int FW = 32;
    localparam int NF = 5;
    localparam int PW = NF * FW;
    localparam int W1 = 256;

    logic clk     = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk = ~clk;

    bsg_chip_mem_link_if #(.msg_width_p(MW), .flit_width_p(FW)) m0 ();
    bsg_chip_mem_link_if #(.msg_width_p(MW), .flit_width_p(W1)) m1 ();

    bsg_chip_mem_link #(.msg_width_p(MW), .flit_width_p(FW)) u0 (
        .clk_i(clk), .reset_i(reset_i), .link_if(m0.slave));
    bsg_chip_mem_link #(.msg_width_p(MW), .flit_width_p(W1)) u1 (
        .clk_i(clk), .reset_i(reset_i), .link_if(m1.slave));

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [FW-1:0] tx_q[$];
    logic [FW-1:0] rx_fl[$];
    logic          pend = 1'b0;
    logic [MW-1:0] pend_val;
    logic          stall_prev = 1'b0;
    logic [FW-1:0] stall_data;
    logic          cmd_taken = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_msg();
        logic [PW-1:0] r;
        for (int i = 0; i < NF; i++) r[i*FW +: FW] = $urandom();
        return r[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] assemble();
        logic [PW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NF; k++) acc = acc | (PW'(rx_fl[k]) << (k * FW));
        return acc[MW-1:0];
    endfunction

    // One clock of the default instance: compare against the model, then advance.
    task automatic tick();
        #1;
        cmd_taken = 1'b0;
        check("link_v", m0.link_v_o, tx_q.size() != 0);
        check("cmd_ready", m0.mem_cmd_ready_o,
              (tx_q.size() == 0) || (m0.link_ready_i && tx_q.size() == 1));
        if (stall_prev) check("link_hold", m0.link_data_o, stall_data);
        if (m0.link_v_o && m0.link_ready_i) begin
            if (tx_q.size() == 0) check("tx_spurious", m0.link_v_o, 1'b0);
            else check("tx_flit", m0.link_data_o, tx_q.pop_front());
        end
        stall_prev = m0.link_v_o && !m0.link_ready_i;
        stall_data = m0.link_data_o;
        if (m0.mem_cmd_v_i && m0.mem_cmd_ready_o) begin
            for (int k = 0; k < NF; k++) tx_q.push_back(FW'(m0.mem_cmd_i >> (k * FW)));
            cmd_taken = 1'b1;
        end
        check("link_ready_o", m0.link_ready_o, !pend);
        check("resp_v", m0.mem_resp_v_o, pend);
        if (pend) check("resp_val", m0.mem_resp_o, pend_val);
        if (pend && m0.mem_resp_yumi_i) begin
            pend = 1'b0;
        end else if (m0.link_v_i && !pend) begin
            rx_fl.push_back(m0.link_data_i);
            if (rx_fl.size() == NF) begin
                pend_val = assemble();
                pend = 1'b1;
                rx_fl.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, m0.mem_cmd_ready_o, 1'b1);
        check({tag, "_link_v"}, m0.link_v_o, 1'b0);
        check({tag, "_link_ready"}, m0.link_ready_o, 1'b1);
        check({tag, "_resp_v"}, m0.mem_resp_v_o, 1'b0);
        check({tag, "_link_data"}, m0.link_data_o, 32'h0000_0000);
        check({tag, "_resp"}, m0.mem_resp_o, 136'h0);
    endtask

    logic [FW-1:0] exp035 [NF];
    logic [3:0]    pat;
    logic [MW-1:0] c;
    logic [W1-1:0] f;

    initial begin
        exp035 = '{32'h0B0A0908, 32'h0F0E0D0C, 32'h76543210, 32'hFEDCBA98, 32'h00000080};
        pat = 4'b1001;
        m0.mem_cmd_i = '0; m0.mem_cmd_v_i = 1'b0; m0.link_ready_i = 1'b0;
        m0.link_data_i = '0; m0.link_v_i = 1'b0; m0.mem_resp_yumi_i = 1'b0;
        m1.mem_cmd_i = '0; m1.mem_cmd_v_i = 1'b0; m1.link_ready_i = 1'b0;
        m1.link_data_i = '0; m1.link_v_i = 1'b0; m1.mem_resp_yumi_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_n1_ready", m1.mem_cmd_ready_o, 1'b1);
        check("rst_n1_link_v", m1.link_v_o, 1'b0);
        reset_i = 1'b1;
        #1;

        // Single known command at full link rate.
        m0.mem_cmd_i = 136'h80_FEDCBA98_76543210_0F0E0D0C_0B0A0908;
        m0.mem_cmd_v_i = 1'b1;
        m0.link_ready_i = 1'b1;
        tick();
        m0.mem_cmd_v_i = 1'b0;
        for (int k = 0; k < NF; k++) begin
            #1;
            check($sformatf("known_flit%0d", k), m0.link_data_o, exp035[k]);
            tick();
        end
        #1;
        check("known_done", m0.link_v_o, 1'b0);

        // Back-to-back commands: second accepted on the first one's last flit.
        m0.mem_cmd_i = rand_msg();
        m0.mem_cmd_v_i = 1'b1;
        tick();
        m0.mem_cmd_i = rand_msg();
        for (int k = 0; k < 2 * NF; k++) begin
            #1;
            check($sformatf("b2b_v%0d", k), m0.link_v_o, 1'b1);
            check($sformatf("b2b_ready%0d", k), m0.mem_cmd_ready_o, (k == 4) || (k == 9));
            tick();
            if (k == 4) m0.mem_cmd_v_i = 1'b0;
        end
        #1;
        check("b2b_done", m0.link_v_o, 1'b0);

        // Stalling link: ready pattern 1,0,0,1.
        m0.mem_cmd_i = rand_msg();
        m0.mem_cmd_v_i = 1'b1;
        tick();
        m0.mem_cmd_v_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            m0.link_ready_i = pat[i % 4];
            tick();
        end
        m0.link_ready_i = 1'b1;
        #1;
        check("stall_done", m0.link_v_o, 1'b0);

        // Known inbound flits with a delayed consumer; junk offered while full.
        for (int k = 0; k < NF; k++) begin
            m0.link_v_i = 1'b1;
            m0.link_data_i = 32'h11111111 * (k + 1);
            tick();
        end
        m0.link_data_i = 32'hDEADBEEF;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("rx_known_v", m0.mem_resp_v_o, 1'b1);
            check("rx_known_val", m0.mem_resp_o, 136'h55_44444444_33333333_22222222_11111111);
            check("rx_known_lrdy", m0.link_ready_o, 1'b0);
            tick();
        end
        m0.mem_resp_yumi_i = 1'b1;
        tick();
        m0.mem_resp_yumi_i = 1'b0;
        m0.link_v_i = 1'b0;
        #1;
        check("rx_after_yumi_lrdy", m0.link_ready_o, 1'b1);
        check("rx_after_yumi_v", m0.mem_resp_v_o, 1'b0);

        // Reset in the middle of a message on both paths.
        m0.mem_cmd_i = rand_msg();
        m0.mem_cmd_v_i = 1'b1;
        m0.link_v_i = 1'b1;
        m0.link_data_i = $urandom();
        tick();
        m0.mem_cmd_v_i = 1'b0;
        m0.link_data_i = $urandom();
        tick();
        m0.link_v_i = 1'b0;
        tick();
        reset_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tx_q.delete();
        rx_fl.delete();
        pend = 1'b0;
        stall_prev = 1'b0;
        #1;
        reset_i = 1'b1;
        m0.mem_cmd_i = rand_msg();
        m0.mem_cmd_v_i = 1'b1;
        tick();
        m0.mem_cmd_v_i = 1'b0;
        for (int k = 0; k < NF; k++) begin
            m0.link_v_i = 1'b1;
            m0.link_data_i = $urandom();
            tick();
        end
        m0.link_v_i = 1'b0;
        #1;
        check("postrst_resp_v", m0.mem_resp_v_o, 1'b1);
        m0.mem_resp_yumi_i = 1'b1;
        tick();
        m0.mem_resp_yumi_i = 1'b0;

        // Randomized traffic on both directions at once.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!m0.mem_cmd_v_i || cmd_taken) begin
                m0.mem_cmd_v_i = ($urandom_range(0, 2) != 0);
                m0.mem_cmd_i = rand_msg();
            end
            m0.link_ready_i = ($urandom_range(0, 3) != 0);
            m0.link_v_i = ($urandom_range(0, 1) == 1);
            m0.link_data_i = $urandom();
            m0.mem_resp_yumi_i = pend && ($urandom_range(0, 1) == 1);
            tick();
        end
        m0.mem_cmd_v_i = 1'b0;
        m0.link_v_i = 1'b0;
        m0.link_ready_i = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            m0.mem_resp_yumi_i = pend;
            tick();
        end
        m0.mem_resp_yumi_i = 1'b0;
        #1;
        check("drain_link_v", m0.link_v_o, 1'b0);
        check("drain_resp_v", m0.mem_resp_v_o, 1'b0);

        // Single-flit instance: one flit per command, one response per flit.
        for (int i = 0; i < 3; i++) begin
            c = rand_msg();
            for (int w = 0; w < W1 / 32; w++) f[w*32 +: 32] = $urandom();
            m1.mem_cmd_i = c;
            m1.mem_cmd_v_i = 1'b1;
            m1.link_ready_i = 1'b1;
            m1.link_v_i = 1'b1;
            m1.link_data_i = f;
            #1;
            check("n1_cmd_ready_idle", m1.mem_cmd_ready_o, 1'b1);
            check("n1_lrdy_idle", m1.link_ready_o, 1'b1);
            tick();
            m1.mem_cmd_v_i = 1'b0;
            m1.link_v_i = 1'b0;
            #1;
            check("n1_link_v", m1.link_v_o, 1'b1);
            check("n1_flit", m1.link_data_o, W1'(c));
            check("n1_cmd_ready_last", m1.mem_cmd_ready_o, 1'b1);
            check("n1_resp_v", m1.mem_resp_v_o, 1'b1);
            check("n1_resp", m1.mem_resp_o, f[MW-1:0]);
            check("n1_lrdy_full", m1.link_ready_o, 1'b0);
            m1.mem_resp_yumi_i = 1'b1;
            tick();
            m1.mem_resp_yumi_i = 1'b0;
            #1;
            check("n1_link_v_done", m1.link_v_o, 1'b0);
            check("n1_resp_v_done", m1.mem_resp_v_o, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
